branch_unit_bht: RTL and testbench

Pipelined branch resolution unit with a built-in bimodal predictor for the rv32i core.
- Evaluates all six RV32I conditional branches on XLEN-wide operands in the execute stage and registers the outcome.
- Flags mispredictions against the fetch-stage prediction and supplies the redirect PC.
- Trains a table of 2-bit saturating counters and keeps saturating branch/mispredict statistics.

---
 rtl/branch_unit_bht.sv | 145 ++++++++++++++
 tb/tb_branch_unit_bht.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/branch_unit_bht.sv
// Branch resolution unit: evaluates RV32I conditional branches, flags mispredictions,
// trains a bimodal table of 2-bit counters and keeps saturating statistics.
module branch_unit_bht #(
  parameter int         XLEN       = 32,
  parameter int         BHT_DEPTH  = 64,
  parameter int         CNT_W      = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_a,
  input  logic [XLEN-1:0]  ex_b,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [XLEN-1:0]  res_redirect_pc,
  output logic             res_illegal,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             eq, lt, ltu;
  logic             taken, illegal, mispredict, accept;
  logic [XLEN-1:0]  redirect_pc;

  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic [XLEN-1:0]  res_redirect_pc_q, res_redirect_pc_d;
  logic             res_illegal_q, res_illegal_d;
  logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  // PC bits outside the table index never influence the prediction.
  logic unused_pred_pc_bits;
  assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  assign pred_idx   = pred_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign pred_taken = bht_q[pred_idx][1];

  assign eq  = (ex_a == ex_b);
  assign lt  = ($signed(ex_a) < $signed(ex_b));
  assign ltu = (ex_a < ex_b);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (ex_funct3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: illegal = 1'b1;
    endcase
  end

  assign mispredict  = taken ^ ex_pred_taken;
  assign redirect_pc = taken ? ex_target : ex_pc + XLEN'(4);
  assign accept      = ex_valid & ~flush;

  always_comb begin
    res_valid_d       = accept;
    res_taken_d       = res_taken_q;
    res_mispredict_d  = res_mispredict_q;
    res_redirect_pc_d = res_redirect_pc_q;
    res_illegal_d     = res_illegal_q;
    if (ex_valid) begin
      res_taken_d       = taken;
      res_mispredict_d  = mispredict;
      res_redirect_pc_d = redirect_pc;
      res_illegal_d     = illegal;
    end
  end

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept) begin
      if (stat_branches_q != '1)
        stat_branches_d = stat_branches_q + CNT_W'(1);
      if (mispredict && stat_mispredicts_q != '1)
        stat_mispredicts_d = stat_mispredicts_q + CNT_W'(1);
    end
  end

  // The read port sees bht_q, so a same-cycle update to the predicted index shows up next cycle.
  always_comb begin
    bht_d = bht_q;
    if (accept && !illegal) begin
      if (taken && bht_q[ex_idx] != 2'b11)
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      else if (!taken && bht_q[ex_idx] != 2'b00)
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht_q[i] <= INIT_STATE;
      res_valid_q        <= 1'b0;
      res_taken_q        <= 1'b0;
      res_mispredict_q   <= 1'b0;
      res_redirect_pc_q  <= '0;
      res_illegal_q      <= 1'b0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      bht_q              <= bht_d;
      res_valid_q        <= res_valid_d;
      res_taken_q        <= res_taken_d;
      res_mispredict_q   <= res_mispredict_d;
      res_redirect_pc_q  <= res_redirect_pc_d;
      res_illegal_q      <= res_illegal_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign res_valid        = res_valid_q;
  assign res_taken        = res_taken_q;
  assign res_mispredict   = res_mispredict_q;
  assign res_redirect_pc  = res_redirect_pc_q;
  assign res_illegal      = res_illegal_q;
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Scoreboard bench for branch_unit_bht built with 4-bit statistics so saturation is reachable.
module tb_branch_unit_bht;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             taken;
    logic             mispredict;
    logic             illegal;
    logic [XLEN-1:0]  redirect;
    logic [CNT_W-1:0] branches;
    logic [CNT_W-1:0] mispredicts;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_a, ex_b, ex_pc, ex_target;
  logic             ex_pred_taken;
  logic             flush;
  logic             res_valid, res_taken, res_mispredict, res_illegal;
  logic [XLEN-1:0]  res_redirect_pc;
  logic [CNT_W-1:0] stat_branches, stat_mispredicts;

  exp_t             sb_q[$];
  logic [1:0]       model_bht [64];
  logic [CNT_W-1:0] model_br, model_mp;
  int               checks   = 0;
  int               failures = 0;

  branch_unit_bht #(.XLEN(XLEN), .BHT_DEPTH(64), .CNT_W(CNT_W), .INIT_STATE(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_redirect_pc(res_redirect_pc), .res_illegal(res_illegal),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one branch for a single cycle; exp_taken is the hand-computed direction.
  task automatic applyStimulus(input logic [2:0] f3, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                               input logic [XLEN-1:0] tgt, input logic pt,
                               input logic fl, input logic exp_taken);
    exp_t e;
    logic ill;
    ex_valid = 1'b1; ex_funct3 = f3; ex_a = a; ex_b = b;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; flush = fl;
    #1;
    checkOutput("pred_pre", {31'd0, pred_taken}, {31'd0, model_bht[pred_pc[7:2]][1]});
    ill          = (f3 == 3'b010) || (f3 == 3'b011);
    e.illegal    = ill;
    e.taken      = ill ? 1'b0 : exp_taken;
    e.mispredict = e.taken ^ pt;
    e.redirect   = e.taken ? tgt : pc + 32'd4;
    if (!fl) begin
      if (model_br != '1) model_br++;
      if (e.mispredict && model_mp != '1) model_mp++;
      e.branches    = model_br;
      e.mispredicts = model_mp;
      sb_q.push_back(e);
      if (!ill) begin
        if (e.taken && model_bht[pc[7:2]] != 2'b11) model_bht[pc[7:2]]++;
        else if (!e.taken && model_bht[pc[7:2]] != 2'b00) model_bht[pc[7:2]]--;
      end
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("pred_post", {31'd0, pred_taken}, {31'd0, model_bht[pred_pc[7:2]][1]});
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: res_valid=1 with no branch outstanding at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("res_taken",      {31'd0, res_taken},      {31'd0, e.taken});
        checkOutput("res_mispredict", {31'd0, res_mispredict}, {31'd0, e.mispredict});
        checkOutput("res_illegal",    {31'd0, res_illegal},    {31'd0, e.illegal});
        checkOutput("res_redirect",   res_redirect_pc,         e.redirect);
        checkOutput("stat_branches",  {28'd0, stat_branches},  {28'd0, e.branches});
        checkOutput("stat_mispred",   {28'd0, stat_mispredicts}, {28'd0, e.mispredicts});
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) model_bht[i] = 2'b01;
    model_br = '0; model_mp = '0;
    rst_n = 1'b0; pred_pc = 32'h100; ex_valid = 1'b0; ex_funct3 = 3'b000;
    ex_a = '0; ex_b = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_pred_taken", {31'd0, pred_taken},      32'd0);
    checkOutput("rst_res_valid",  {31'd0, res_valid},       32'd0);
    checkOutput("rst_res_taken",  {31'd0, res_taken},       32'd0);
    checkOutput("rst_res_misp",   {31'd0, res_mispredict},  32'd0);
    checkOutput("rst_res_ill",    {31'd0, res_illegal},     32'd0);
    checkOutput("rst_redirect",   res_redirect_pc,          32'd0);
    checkOutput("rst_stat_br",    {28'd0, stat_branches},   32'd0);
    checkOutput("rst_stat_mp",    {28'd0, stat_mispredicts}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(3'b000, 32'd5,        32'd5,        32'h200, 32'h180, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b100, 32'hFFFFFFFF, 32'd1,        32'h300, 32'h400, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b110, 32'hFFFFFFFF, 32'd1,        32'h300, 32'h400, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b111, 32'hFFFFFFFF, 32'd1,        32'h300, 32'h400, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b001, 32'd3,        32'd4,        32'h304, 32'h500, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b101, 32'h80000000, 32'd0,        32'h308, 32'h600, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b101, 32'd7,        32'd7,        32'h30C, 32'h700, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b100, 32'd1,        32'hFFFFFFFF, 32'h310, 32'h800, 1'b0, 1'b0, 1'b0);

    // Same index read and trained together: 01 -> 10 -> 11 -> 11.
    pred_pc = 32'h40;
    for (int i = 0; i < 4; i++)
      applyStimulus(3'b000, 32'd9, 32'd9, 32'h40, 32'h1000, 1'b0, 1'b0, 1'b1);
    checkOutput("bht_0x40_strong", {30'd0, dut.bht_q[16]}, 32'd3);

    pred_pc = 32'h44;
    applyStimulus(3'b000, 32'd1, 32'd1, 32'h44, 32'h2000, 1'b0, 1'b1, 1'b1);
    applyStimulus(3'b011, 32'd0, 32'd0, 32'h44, 32'h2000, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b010, 32'd0, 32'd0, 32'h44, 32'h2000, 1'b0, 1'b0, 1'b0);
    checkOutput("bht_0x44_untouched", {30'd0, dut.bht_q[17]}, 32'd1);

    for (int i = 0; i < 20; i++)
      applyStimulus(3'b001, 32'd9, 32'd9, 32'h500 + 32'(i * 4), 32'h3000, 1'b1, 1'b0, 1'b0);

    applyStimulus(3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h4000, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("stat_mp_saturated", {28'd0, stat_mispredicts}, 32'd15);
    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
    checkOutput("idle_res_valid", {31'd0, res_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
